// File: rtl/alu.sv
// 32-bit execute-stage ALU: the result and flags are computed combinationally
// and registered on every rising edge. There is no enable and no handshake.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUOp,
    output logic [WIDTH-1:0] C,
    output logic             zero,
    output logic             overflow
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_SRL  = 3'b100,
        OP_SRA  = 3'b101,
        OP_SLT  = 3'b110,
        OP_SLTU = 3'b111
    } alu_op_e;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] result_next;
    logic             overflow_next;
    logic             zero_next;

    assign sum   = A + B;
    assign diff  = A - B;
    assign shamt = B[4:0];

    always_comb begin
        result_next   = '0;
        overflow_next = 1'b0;
        case (alu_op_e'(ALUOp))
            OP_ADD: begin
                result_next   = sum;
                // Same-sign operands whose sum flips sign.
                overflow_next = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                result_next   = diff;
                overflow_next = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  result_next = A & B;
            OP_OR:   result_next = A | B;
            OP_SRL:  result_next = A >> shamt;
            OP_SRA:  result_next = $unsigned($signed(A) >>> shamt);
            OP_SLT:  result_next = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: result_next = {{(WIDTH-1){1'b0}}, (A < B)};
            default: result_next = '0;
        endcase
    end

    assign zero_next = (result_next == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            C        <= '0;
            zero     <= 1'b1;
            overflow <= 1'b0;
        end else begin
            C        <= result_next;
            zero     <= zero_next;
            overflow <= overflow_next;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed test-plan steps followed by random vectors, checked
// against an arithmetic reference model through an expected-value queue.
module tb_alu;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ALUOp;
    logic [31:0] C;
    logic        zero;
    logic        overflow;

    logic [33:0] exp_q[$];
    int          n_vec;
    int          n_fail;

    alu #(.WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .A(A),
        .B(B),
        .ALUOp(ALUOp),
        .C(C),
        .zero(zero),
        .overflow(overflow)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Reference model written from the operation definitions using 64-bit
    // integer arithmetic rather than bit-level logic.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op, input bit rst);
        longint sa, sb, ua, ub, s, p, q;
        logic [31:0] c;
        bit o;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = longint'(64'd1 << (b % 32));
        o  = 1'b0;
        c  = '0;
        case (op)
            3'd0: begin
                s = sa + sb;
                c = 32'(s);
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                s = sa - sb;
                c = 32'(s);
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: c = a & b;
            3'd3: c = a | b;
            3'd4: c = 32'(ua / p);
            3'd5: begin
                // Floor division by 2^shift.
                if (sa >= 0) q = sa / p;
                else         q = -((-sa + p - 1) / p);
                c = 32'(q);
            end
            3'd6: c = (sa < sb) ? 32'd1 : 32'd0;
            default: c = (ua < ub) ? 32'd1 : 32'd0;
        endcase
        if (rst) begin
            c = '0;
            o = 1'b0;
        end
        return {c, (c == 32'd0), o};
    endfunction

    // Driver: applies one vector and queues its expected result.
    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input bit rst);
        A     = a;
        B     = b;
        ALUOp = op;
        reset = rst;
        exp_q.push_back(model(a, b, op, rst));
        n_vec++;
    endtask

    // Scoreboard: one edge later, compares DUT outputs with the queued value.
    task automatic check(input string tag);
        logic [33:0] e;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        assert (C === e[33:2]) else begin
            n_fail++;
            $error("FAIL %s C got %h exp %h", tag, C, e[33:2]);
        end
        assert (zero === e[1]) else begin
            n_fail++;
            $error("FAIL %s zero got %b exp %b", tag, zero, e[1]);
        end
        assert (overflow === e[0]) else begin
            n_fail++;
            $error("FAIL %s overflow got %b exp %b", tag, overflow, e[0]);
        end
    endtask

    // Directed step with an additional literal expectation on C.
    task automatic step_k(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input bit rst, input logic [31:0] kc);
        drive(a, b, op, rst);
        check(tag);
        assert (C === kc) else begin
            n_fail++;
            $error("FAIL %s_const C got %h exp %h", tag, C, kc);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_vec  = 0;
        n_fail = 0;
        A      = '0;
        B      = '0;
        ALUOp  = '0;
        reset  = 1'b1;
        @(posedge clk);
        #1;

        step_k("reset",     32'h1234_5678, 32'd1, 3'b000, 1'b1, 32'h0);
        step_k("sra10",     32'hF000_0000, 32'd10, 3'b101, 1'b0, 32'hFFFC_0000);
        step_k("srl10",     32'hF000_0000, 32'd10, 3'b100, 1'b0, 32'h003C_0000);
        step_k("sra_hiB",   32'hF000_0000, 32'h2A, 3'b101, 1'b0, 32'hFFFC_0000);
        step_k("srl_hiB",   32'hF000_0000, 32'h2A, 3'b100, 1'b0, 32'h003C_0000);
        step_k("sra0",      32'hF000_0001, 32'h20, 3'b101, 1'b0, 32'hF000_0001);
        step_k("add_ovf",   32'h7FFF_FFFF, 32'd1, 3'b000, 1'b0, 32'h8000_0000);
        step_k("sub_ovf",   32'h8000_0000, 32'd1, 3'b001, 1'b0, 32'h7FFF_FFFF);
        step_k("sub_zero",  32'd5, 32'd5, 3'b001, 1'b0, 32'h0);
        step_k("and",       32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b010, 1'b0, 32'h00F0_00F0);
        step_k("or",        32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b011, 1'b0, 32'hFFF0_FFF0);
        step_k("slt",       32'hFFFF_FFFF, 32'd1, 3'b110, 1'b0, 32'd1);
        step_k("sltu",      32'hFFFF_FFFF, 32'd1, 3'b111, 1'b0, 32'd0);
        step_k("slt_swap",  32'd1, 32'hFFFF_FFFF, 3'b110, 1'b0, 32'd0);
        step_k("sltu_swap", 32'd1, 32'hFFFF_FFFF, 3'b111, 1'b0, 32'd1);

        // Opcode changes every cycle, with reset in the middle of the stream.
        for (int i = 0; i < 8; i++) begin
            drive(32'h8765_4321 + 32'(i), 32'h0000_1003, 3'(i), (i == 4));
            check($sformatf("stream%0d", i));
        end

        // An opcode change before the edge only affects the captured result.
        ALUOp = 3'b010;
        #2;
        drive(32'hA5A5_A5A5, 32'h0000_0004, 3'b100, 1'b0);
        check("midcycle");

        for (int i = 0; i < 400; i++) begin
            drive(pick_operand(), pick_operand(), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 24) == 0));
            check($sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
